// File: rtl/commit_order_buffer.sv
// commit_order_buffer
// Collects monitor records from NUM_CH writeback channels in any order and
// releases them one per cycle in strictly ascending instruction order.
// Each record lives in the slot given by the low bits of its order; a write
// is allowed only inside the window [head, head+DEPTH).
// Optional build macro: COMMIT_ORDER_CHECK_EN adds a sticky order_err output.
module commit_order_buffer #(
   parameter int NUM_CH = 2,
   parameter int DEPTH  = 16,
   parameter int REC_W  = 343
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CH-1:0]           in_valid,
   input  logic [NUM_CH*64-1:0]        in_order,
   input  logic [NUM_CH*REC_W-1:0]     in_rec,
   output logic [NUM_CH-1:0]           in_ready,
   input  logic                        flush,
   input  logic [63:0]                 flush_order,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [63:0]                 out_order,
   output logic [REC_W-1:0]            out_rec,
   output logic [$clog2(DEPTH):0]      occupancy
`ifdef COMMIT_ORDER_CHECK_EN
   ,
   output logic                        order_err
`endif
);

   localparam int AW = $clog2(DEPTH);

   logic [63:0]       r_head;
   logic [DEPTH-1:0]  r_vld;
   logic [63:0]       r_ord [DEPTH];
   logic [REC_W-1:0]  r_rec [DEPTH];
   logic [AW:0]       r_occ;

   logic [63:0]       w_ord  [NUM_CH];
   logic [AW-1:0]     w_slot [NUM_CH];
   logic [NUM_CH-1:0] w_win;
   logic [NUM_CH-1:0] w_acc;
   logic [AW-1:0]     w_head_slot;
   logic              w_ret;
   logic [AW:0]       w_nacc;

   // Per-channel order, target slot and window test against the current head.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         w_ord[c]  = in_order[c*64 +: 64];
         w_slot[c] = w_ord[c][AW-1:0];
         w_win[c]  = ((w_ord[c] - r_head) < 64'(DEPTH));
      end
   end

   // Accept when in window, slot free, no flush, and no lower channel claims the slot.
   always_comb begin
      in_ready = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         in_ready[c] = w_win[c] & ~r_vld[w_slot[c]] & ~flush;
         for (int k = 0; k < c; k++) begin
            if (in_valid[k] && w_win[k] && (w_slot[k] == w_slot[c]))
               in_ready[c] = 1'b0;
         end
      end
   end

   // Head muxing, handshakes and the number of accepted writes this cycle.
   always_comb begin
      w_head_slot = r_head[AW-1:0];
      out_valid   = r_vld[w_head_slot];
      out_order   = r_ord[w_head_slot];
      out_rec     = r_rec[w_head_slot];
      w_ret       = out_valid & out_ready;
      w_acc       = in_valid & in_ready;
      w_nacc      = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (w_acc[c])
            w_nacc = w_nacc + {{AW{1'b0}}, 1'b1};
      end
   end

   assign occupancy = r_occ;

   // Entry storage, head pointer and occupancy; flush overrides writes and retires.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head <= '0;
         r_vld  <= '0;
         r_occ  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_ord[i] <= '0;
            r_rec[i] <= '0;
         end
      end else if (flush) begin
         r_vld  <= '0;
         r_head <= flush_order;
         r_occ  <= '0;
      end else begin
         if (w_ret) begin
            r_vld[w_head_slot] <= 1'b0;
            r_head             <= r_head + 64'd1;
         end
         for (int c = 0; c < NUM_CH; c++) begin
            if (w_acc[c]) begin
               r_vld[w_slot[c]] <= 1'b1;
               r_ord[w_slot[c]] <= w_ord[c];
               r_rec[w_slot[c]] <= in_rec[c*REC_W +: REC_W];
            end
         end
         r_occ <= r_occ + w_nacc - {{AW{1'b0}}, w_ret};
      end
   end

`ifdef COMMIT_ORDER_CHECK_EN
   logic w_err_set;
   logic r_err;

   // Flag out-of-window presentations while not full, and duplicate writes of a buffered order.
   always_comb begin
      w_err_set = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (in_valid[c] && !w_win[c] && (r_occ < (AW+1)'(DEPTH)))
            w_err_set = 1'b1;
         if (in_valid[c] && r_vld[w_slot[c]] && (r_ord[w_slot[c]] == w_ord[c]))
            w_err_set = 1'b1;
      end
   end

   // Sticky error flag, cleared by reset or flush.
   always_ff @(posedge clk) begin
      if (rst || flush)
         r_err <= 1'b0;
      else if (w_err_set)
         r_err <= 1'b1;
   end

   assign order_err = r_err;
`endif

endmodule

// File: tb/tb_commit_order_buffer.sv
// Testbench for commit_order_buffer: directed scenarios plus random traffic,
// checked against an associative-array model of the order window.
module tb_commit_order_buffer;

   localparam int NUM_CH = 2;
   localparam int DEPTH  = 16;
   localparam int REC_W  = 343;

   logic                    clk;
   logic                    rst;
   logic [NUM_CH-1:0]       in_valid;
   logic [NUM_CH*64-1:0]    in_order;
   logic [NUM_CH*REC_W-1:0] in_rec;
   logic [NUM_CH-1:0]       in_ready;
   logic                    flush;
   logic [63:0]             flush_order;
   logic                    out_valid;
   logic                    out_ready;
   logic [63:0]             out_order;
   logic [REC_W-1:0]        out_rec;
   logic [$clog2(DEPTH):0]  occupancy;

   commit_order_buffer #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .REC_W(REC_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_order(in_order), .in_rec(in_rec), .in_ready(in_ready),
      .flush(flush), .flush_order(flush_order),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_order(out_order), .out_rec(out_rec), .occupancy(occupancy)
   );

   typedef struct packed {
      logic [63:0]      o;
      logic [REC_W-1:0] r;
   } exp_t;

   exp_t             exp_q [$];
   logic [REC_W-1:0] m_rec [logic [63:0]];
   logic [63:0]      m_head;
   int               n_vec;
   int               n_err;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [REC_W-1:0] rnd_rec();
      logic [REC_W-1:0] r;
      r = '0;
      for (int i = 0; i < 11; i++) r = {r[REC_W-33:0], $urandom()};
      return r;
   endfunction

   // Monitor: every retirement the DUT performs must match the next expected record.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_retire: got order %0h expected none", out_order);
            end else begin
               e = exp_q.pop_front();
               chk("out_order", out_order, e.o);
               n_vec++;
               if (out_rec !== e.r) begin
                  n_err++;
                  $display("FAIL out_rec: order %0h got %h expected %h", e.o, out_rec, e.r);
               end
            end
         end
      end
   end

   // One clock of stimulus; checks in_ready/out_valid/occupancy against the model, then advances it.
   task automatic do_cycle(input logic r, input logic v0, input logic [63:0] o0,
                           input logic v1, input logic [63:0] o1,
                           input logic fl, input logic [63:0] fo, input logic ordy);
      logic [REC_W-1:0] r0, r1;
      logic e0, e1, rdy;
      r0 = rnd_rec();
      r1 = rnd_rec();
      @(posedge clk);
      #1;
      rst         = r;
      in_valid    = {v1, v0};
      in_order    = {o1, o0};
      in_rec      = {r1, r0};
      flush       = fl;
      flush_order = fo;
      rdy         = ordy & ~r & ~fl;
      out_ready   = rdy;
      #1;
      e0 = ((o0 - m_head) < 64'(DEPTH)) && !m_rec.exists(o0) && !fl;
      e1 = ((o1 - m_head) < 64'(DEPTH)) && !m_rec.exists(o1) && !fl && !(v0 && (o0 == o1));
      if (!r) begin
         chk("in_ready", 64'(in_ready), 64'({e1, e0}));
         chk("out_valid", 64'(out_valid), 64'(m_rec.exists(m_head)));
         chk("occupancy", 64'(occupancy), 64'(m_rec.num()));
      end
      if (r) begin
         m_rec.delete();
         m_head = '0;
      end else if (fl) begin
         m_rec.delete();
         m_head = fo;
      end else begin
         if (rdy && m_rec.exists(m_head)) begin
            exp_q.push_back({m_head, m_rec[m_head]});
            m_rec.delete(m_head);
            m_head = m_head + 64'd1;
         end
         if (v0 && e0) m_rec[o0] = r0;
         if (v1 && e1) m_rec[o1] = r1;
      end
   endtask

   task automatic idle(input int n, input logic ordy);
      for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, 0, 0, 0, ordy);
   endtask

   task automatic do_reset();
      do_cycle(1, 0, 0, 0, 0, 0, 0, 0);
      do_cycle(1, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      logic [63:0] o0, o1, fo;
      n_vec = 0;
      n_err = 0;
      m_head = '0;
      rst = 1'b1; in_valid = '0; in_order = '0; in_rec = '0;
      flush = 1'b0; flush_order = '0; out_ready = 1'b0;

      // In-order single channel
      do_reset();
      for (int i = 0; i < 3; i++) do_cycle(0, 1, 64'(i), 0, 0, 0, 0, 1);
      idle(3, 1);

      // Reverse arrival
      do_reset();
      do_cycle(0, 1, 64'd3, 1, 64'd2, 0, 0, 1);
      do_cycle(0, 1, 64'd1, 1, 64'd0, 0, 0, 1);
      idle(6, 1);

      // Full and back-pressure
      do_reset();
      for (int i = 0; i < 8; i++) do_cycle(0, 1, 64'(2*i), 1, 64'(2*i+1), 0, 0, 0);
      do_cycle(0, 1, 64'd16, 0, 0, 0, 0, 0);
      do_cycle(0, 1, 64'd16, 0, 0, 0, 0, 1);
      do_cycle(0, 1, 64'd16, 0, 0, 0, 0, 0);
      idle(20, 1);

      // Collision
      do_reset();
      do_cycle(0, 1, 64'd5, 1, 64'd5, 0, 0, 0);
      do_cycle(0, 0, 0, 1, 64'd5, 0, 0, 0);
      idle(2, 0);

      // Flush with concurrent write
      do_reset();
      for (int i = 0; i < 3; i++) do_cycle(0, 1, 64'(2*i), 1, 64'(2*i+1), 0, 0, 0);
      do_cycle(0, 1, 64'd6, 0, 0, 1, 64'd100, 1);
      do_cycle(0, 1, 64'd100, 1, 64'd5, 0, 0, 0);
      idle(3, 1);

      // Wrap-around of the 64-bit order
      do_cycle(0, 0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
      do_cycle(0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
      do_cycle(0, 1, 64'd0, 1, 64'd1, 0, 0, 1);
      idle(4, 1);
      do_cycle(0, 1, 64'd2, 0, 0, 0, 0, 1);
      idle(2, 1);

      // Random traffic with occasional flush and reset
      for (int n = 0; n < 3000; n++) begin
         o0 = m_head + 64'($urandom_range(0, 19));
         o1 = m_head + 64'($urandom_range(0, 19));
         if ($urandom_range(0, 15) == 0) o0 = m_head - 64'd1;
         if ($urandom_range(0, 7) == 0) o1 = o0;
         if ($urandom_range(0, 1) == 0) fo = m_head + 64'($urandom_range(0, 40));
         else fo = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
         do_cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), o0,
                  ($urandom_range(0, 3) != 0), o1, ($urandom_range(0, 79) == 0), fo,
                  ($urandom_range(0, 3) != 0));
      end
      idle(40, 1);
      @(posedge clk);
      @(posedge clk);
      chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/commit_order_buffer.md
# commit_order_buffer

Parametrised in-order commit buffer between the writeback channels of the pipeline and the RVFI-style monitor port. It accepts packed monitor records from `NUM_CH` independent writeback channels, in any order, each tagged with its 64-bit instruction order. It releases them one per cycle in strict ascending order. It generalises the single-channel, pass-through writeback monitor hookup to multiple channels, out-of-order arrival, back-pressure and flush.

## Interface
Parameters:
- `NUM_CH`, 2: number of writeback input channels (1..8).
- `DEPTH`, 16: buffer entries; power of two, ≥ 2.
- `REC_W`, 343: width of the packed monitor record. The payload is opaque to this block: inst, rs1/rs2 addr and data, rd addr/wdata, pc_rdata/wdata, mem addr/masks/data.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  NUM_CH  per-channel record valid.
- `in_order`  in  NUM_CH×64  per-channel instruction order tag.
- `in_rec`  in  NUM_CH×REC_W  per-channel packed record.
- `in_ready`  out  NUM_CH  per-channel accept.
- `flush`  in  1  discard all buffered records and rebase.
- `flush_order`  in  64  head order after a flush.
- `out_valid`  out  1  head record available.
- `out_ready`  in  1  monitor consumes head record.
- `out_order`  out  64  order of head record.
- `out_rec`  out  REC_W  head record.
- `occupancy`  out  $clog2(DEPTH)+1  number of valid entries.

## Operation
- State:
  - `head` (64-bit, next order to retire).
  - `DEPTH` entries, each holding {valid, order, rec}.
  - Slot index = order[$clog2(DEPTH)-1:0].
- Window: channel c may write only if `in_order[c] - head` (64-bit unsigned, wrap-around) is `< DEPTH`.
  - `in_ready[c]` = window ok AND target slot not valid AND not `flush`.
  - `in_ready` may depend combinationally on `in_order`. This is the only input-to-output combinational path besides `out_ready`-independent head muxing.
- Write: on `in_valid[c] & in_ready[c]`, the slot gets valid=1, order, and rec.
- Same-slot collision: two channels targeting the same slot in the same cycle → the lowest-index channel is accepted; the higher channels see `in_ready=0`.
- Retire: `out_valid` = entry[head slot].valid. On `out_valid & out_ready`, that slot is cleared and `head` increments by 1 (64-bit wrap).
- Simultaneous write and retire on the same slot is impossible, because the window is evaluated against the pre-increment `head`.
- Flush: has priority over all writes and retires in its cycle.
  - All valid bits are cleared.
  - `head` ← `flush_order`.
  - `in_ready` is forced to 0 during the flush cycle.
- `occupancy` = count of valid entries, registered. It is updated each cycle by the number of accepted writes minus retires (0 after flush).
- `out_order` and `out_rec` reflect the head slot contents; they are don't-care when `out_valid=0` but must not be X after reset (entry storage is reset to 0).

## Timing
- Reset (`rst`=1 at an edge):
  - `head`=0.
  - All entries invalid and zero.
  - `occupancy`=0; `out_valid`=0.
  - `in_ready` reflects the empty buffer with head=0 once `rst` is deasserted.
  - Reset mid-operation discards everything exactly like reset from idle.
- Latency: a record written at edge N is visible on `out_*` after edge N. It is retirable in cycle N+1 at the earliest; there is no same-cycle bypass.
- Throughput: up to `NUM_CH` writes and 1 retire per cycle.
- Full: when occupancy = DEPTH, all `in_ready`=0 until a retire.
- An order outside the window (including already-retired orders) is never accepted; the channel must hold `in_valid` and its data stable until `in_ready`.
- Out-of-order arrival never stalls the output beyond the missing head order: `out_valid` stays 0 until the `head` order is written.

## Configuration
- `COMMIT_ORDER_CHECK_EN`
  - Defined: adds a sticky output `order_err` (1 bit, reset 0, cleared by `rst` or `flush`). It is set on the edge after any cycle where either:
    - `in_valid[c]` with `in_order[c] - head ≥ DEPTH` while `occupancy < DEPTH`, or
    - a write targets a valid slot holding the identical order.
  - Not defined: port absent; no checking logic.

## Test plan
- Reset then in-order single channel: ch0 writes orders 0,1,2 on consecutive cycles, `out_ready`=1 → `out_order` 0,1,2 appear one cycle after each write; `occupancy` returns to 0.
- Reverse arrival: ch0 writes 3, ch1 writes 2, then ch0 writes 1, ch1 writes 0 → `out_valid` stays 0 until order 0 is written, then orders 0,1,2,3 retire on 4 consecutive cycles.
- Full/back-pressure, DEPTH=16, `out_ready`=0: write orders 0..15 → `occupancy`=16; order 16 gets `in_ready`=0. One retire of order 0 → order 16 is accepted next cycle.
- Collision: ch0 and ch1 both present order 5 in one cycle → ch0 accepted, ch1 `in_ready`=0. With `COMMIT_ORDER_CHECK_EN`, if ch1 holds order 5 into the next cycle → `order_err`=1.
- Flush: with orders 0..5 buffered, assert `flush` with `flush_order`=100 plus a concurrent ch0 write → `occupancy`=0 and `out_valid`=0 next cycle; order 100 is accepted afterwards, order 5 is refused.
- Wrap: `flush_order`=64'hFFFF_FFFF_FFFF_FFFE, write orders …FFFE, …FFFF, 0, 1 → all four retire in order and `head` wraps to 2.
